// File: rtl/seg_pkg.sv
// Shared types and default thresholds for the balance sequencer.
package seg_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RAMP  = 3'd2,
    ST_BAL   = 3'd3,
    ST_FAULT = 3'd4
  } seg_state_e;

  localparam logic [12:0]        DEF_MIN_RIDER_WT = 13'h0200;
  localparam logic [12:0]        DEF_WT_HYST      = 13'h0040;
  localparam logic signed [15:0] DEF_PTCH_LIM     = 16'sd1536;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/rider_detect.sv
// Rider presence from summed load cells with hysteresis and sample debounce.
module rider_detect
  import seg_pkg::*;
#(
  parameter logic [12:0] MIN_RIDER_WT = DEF_MIN_RIDER_WT,
  parameter logic [12:0] WT_HYST      = DEF_WT_HYST,
  parameter int unsigned DEB_SMPLS    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        rider_on
);

  localparam logic [12:0]      OFF_THR = MIN_RIDER_WT - WT_HYST;
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_SMPLS);

  logic [12:0]      sum;
  logic             raw_on;
  logic             raw_off;
  logic             disagree;
  logic [CNT_W-1:0] deb_cnt;

  assign sum      = {1'b0, lft_ld} + {1'b0, rght_ld};
  assign raw_on   = (sum > MIN_RIDER_WT);
  assign raw_off  = (sum < OFF_THR);
  // Inside the hysteresis band neither raw flag is set, so it counts as agreement
  assign disagree = (raw_on && !rider_on) || (raw_off && rider_on);

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt  <= '0;
      rider_on <= 1'b0;
    end else if (nxt) begin
      if (disagree) begin
        if (deb_cnt == DEB_MAX - CNT_W'(1)) begin
          deb_cnt  <= '0;
          rider_on <= !rider_on;
        end else begin
          deb_cnt <= deb_cnt + CNT_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/balance_seq.sv
// Power-on / soft-start / balance / tilt-fault sequencer driving the pitch PID controls.
module balance_seq
  import seg_pkg::*;
#(
  parameter logic [12:0]        MIN_RIDER_WT = DEF_MIN_RIDER_WT,
  parameter logic [12:0]        WT_HYST      = DEF_WT_HYST,
  parameter int unsigned        DEB_SMPLS    = 4,
  parameter logic signed [15:0] PTCH_LIM     = DEF_PTCH_LIM,
  parameter int unsigned        FAULT_SMPLS  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               nxt,
  input  logic signed [15:0] ptch,
  input  logic [11:0]        lft_ld,
  input  logic [11:0]        rght_ld,
  input  logic               pwr_req,
  input  logic [7:0]         ss_tmr,
  output logic               vld,
  output logic               pwr_up,
  output logic               rider_off,
  output logic               moto_en,
  output logic               tilt_flt,
  output logic [2:0]         state
);

  localparam logic signed [15:0] NEG_LIM = -PTCH_LIM;
  localparam logic [CNT_W-1:0]   FLT_MAX = CNT_W'(FAULT_SMPLS);

  seg_state_e       state_q;
  seg_state_e       state_d;
  logic             rider_on;
  logic [CNT_W-1:0] flt_cnt;
  logic             over_tilt;
  logic             flt_hit;
  logic             running_q;
  logic             running_d;

  rider_detect #(
    .MIN_RIDER_WT(MIN_RIDER_WT),
    .WT_HYST     (WT_HYST),
    .DEB_SMPLS   (DEB_SMPLS)
  ) u_rider_detect (
    .clk     (clk),
    .rst     (rst),
    .nxt     (nxt),
    .lft_ld  (lft_ld),
    .rght_ld (rght_ld),
    .rider_on(rider_on)
  );

  assign over_tilt = (ptch > PTCH_LIM) || (ptch < NEG_LIM);
  assign flt_hit   = (flt_cnt == FLT_MAX);
  assign running_q = (state_q == ST_RAMP) || (state_q == ST_BAL);
  assign running_d = (state_d == ST_RAMP) || (state_d == ST_BAL);

  // Over-tilt run length; only meaningful while the motor is driven
  always_ff @(posedge clk) begin
    if (rst || !running_q) begin
      flt_cnt <= '0;
    end else if (nxt) begin
      if (!over_tilt)          flt_cnt <= '0;
      else if (!flt_hit)       flt_cnt <= flt_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_OFF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF:   if (pwr_req) state_d = ST_IDLE;
      ST_IDLE:  if (rider_on) state_d = ST_RAMP;
      ST_RAMP: begin
        if (flt_hit)                state_d = ST_FAULT;
        else if (!rider_on)         state_d = ST_IDLE;
        else if (ss_tmr == 8'hFF)   state_d = ST_BAL;
      end
      ST_BAL: begin
        if (flt_hit)                state_d = ST_FAULT;
        else if (!rider_on)         state_d = ST_IDLE;
      end
      ST_FAULT: if (!rider_on) state_d = ST_IDLE;
      default:  state_d = ST_OFF;
    endcase
    // Losing the power switch overrides everything
    if (!pwr_req) state_d = ST_OFF;
  end

  // Outputs decoded from the next state so they move with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld       <= 1'b0;
      pwr_up    <= 1'b0;
      rider_off <= 1'b1;
      moto_en   <= 1'b0;
      tilt_flt  <= 1'b0;
    end else begin
      vld       <= nxt && running_q;
      pwr_up    <= running_d;
      rider_off <= !running_d;
      moto_en   <= running_d;
      tilt_flt  <= (state_d == ST_FAULT);
    end
  end

  assign state = state_q;

endmodule

// File: doc/balance_seq.md
Name: balance_seq

Overview:
- Top-level sequencer for the pitch PID controller.
- Drives the PID's `vld`, `pwr_up` and `rider_off` controls, and owns the motor enable.
- Detects the rider from the two load cells using threshold, hysteresis and debounce.
- Walks the power-on / soft-start / balance / tilt-fault sequence. Sits between the inertial interface, the load-cell A2D results and the PID block.

Parameters:
- MIN_RIDER_WT, 13'h0200, combined load-cell sum above which the rider is "on".
- WT_HYST, 13'h0040, hysteresis. The rider is "off" when sum < MIN_RIDER_WT - WT_HYST.
- DEB_SMPLS, 4, consecutive nxt samples of a consistent rider reading needed to flip the debounced rider status (range 1..15).
- PTCH_LIM, 16'sd1536, magnitude of ptch beyond which a sample counts as over-tilt.
- FAULT_SMPLS, 8, consecutive over-tilt samples that trigger FAULT (range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- nxt  in  1  one-cycle pulse: new ptch/ptch_rt sample available
- ptch  in  16  signed pitch, valid when nxt=1
- lft_ld  in  12  unsigned left load-cell reading, sampled on nxt
- rght_ld  in  12  unsigned right load-cell reading, sampled on nxt
- pwr_req  in  1  level: operator power switch on
- ss_tmr  in  8  soft-start timer returned by PID
- vld  out  1  integrator update strobe to PID
- pwr_up  out  1  soft-start enable to PID
- rider_off  out  1  integrator clear to PID
- moto_en  out  1  motor driver enable
- tilt_flt  out  1  high while in FAULT
- state  out  3  current state, for debug/LEDs

Behaviour:
- Clocking and reset:
  - Single clock domain. All outputs are registered.
  - rst is sampled on the clk edge only.
  - Reset values: state=OFF, vld=0, pwr_up=0, rider_off=1, moto_en=0, tilt_flt=0, debounce counter=0, debounced rider=0, fault counter=0.
- Rider detection (on nxt only):
  - sum = lft_ld + rght_ld, computed 13-bit unsigned with no overflow.
  - Raw "on" when sum > MIN_RIDER_WT. Raw "off" when sum < MIN_RIDER_WT - WT_HYST. Otherwise "hold".
  - If raw disagrees with the debounced value, the counter increments. At DEB_SMPLS the debounced value flips and the counter clears.
  - A raw equal to the debounced value, or "hold", clears the counter.
- Tilt check (on nxt only):
  - Over-tilt when ptch > PTCH_LIM or ptch < -PTCH_LIM. Equality is not over-tilt.
  - The fault counter increments on over-tilt and saturates at FAULT_SMPLS.
  - A non-over-tilt sample clears the counter.
  - The counter is held at 0 outside RAMP/BAL.
- States (3-bit encoding): OFF=0, IDLE=1, RAMP=2, BAL=3, FAULT=4.
- Global override: pwr_req=0 in any state goes to OFF next cycle. This has priority over every other transition.
- OFF -> IDLE when pwr_req=1.
- IDLE -> RAMP when debounced rider=1.
- RAMP:
  - -> BAL when ss_tmr==8'hFF.
  - -> IDLE when debounced rider=0.
  - -> FAULT when the fault counter reaches FAULT_SMPLS.
  - Priority: FAULT > IDLE > BAL.
- BAL:
  - -> FAULT when the fault counter reaches FAULT_SMPLS.
  - -> IDLE when debounced rider=0.
  - FAULT has priority.
- FAULT -> IDLE only when debounced rider=0. Tilt returning in range alone does not exit.
- Output decode, registered from the next state so outputs change on the same edge as state:
  - pwr_up=1 in RAMP and BAL only.
  - rider_off=0 in RAMP and BAL only.
  - moto_en=1 in RAMP and BAL.
  - tilt_flt=1 in FAULT.
- vld:
  - vld = registered nxt, one-cycle latency, gated by the state on the cycle nxt arrived (RAMP or BAL).
  - Always exactly one cycle wide per nxt.
- Leaving RAMP/BAL drops pwr_up, which resets PID's ss_tmr to 0. Every re-entry to RAMP therefore restarts the soft start.
- Reset or pwr_req drop mid-ramp:
  - All outputs return to reset values at the next edge.
  - The debounced rider status is retained on pwr_req drop and cleared only by rst.

Decomposition:
- Shared package seg_pkg:
  - state enum (OFF/IDLE/RAMP/BAL/FAULT, 3-bit).
  - Default constants for MIN_RIDER_WT, WT_HYST, PTCH_LIM.
- One sub-module rider_detect:
  - Inputs: clk, rst, nxt, lft_ld, rght_ld.
  - Output: debounced rider_on.
  - Contains the sum, hysteresis compare and debounce counter. Its parameters are MIN_RIDER_WT, WT_HYST and DEB_SMPLS.
- The state machine, tilt counter and output decode live in balance_seq.

Test Plan:
1. Power-up: rst, then pwr_req=1 with lft_ld=rght_ld=12'h150 (sum 0x2A0) for 4 nxt pulses -> OFF→IDLE→RAMP on the 4th nxt; pwr_up=1, rider_off=0, moto_en=1 next edge.
2. Hysteresis: in BAL, sum=0x1D0 (inside the band) for 10 nxt -> stays BAL. Sum=0x1B0 for 3 nxt -> stays BAL; 4th nxt -> IDLE, rider_off=1. A single 0x300 sample mid-sequence restarts the count.
3. Soft-start completion: in RAMP, drive ss_tmr=8'hFE then 8'hFF -> BAL on the cycle after 8'hFF. A vld pulse follows each nxt by one cycle in both states; no vld in IDLE.
4. Tilt fault: in BAL, ptch=16'sd1537 for 7 nxt then 16'sd0 -> no fault. ptch=-16'sd1537 for 8 nxt -> FAULT, tilt_flt=1, moto_en=0, pwr_up=0. ptch=±1536 never counts.
5. Fault exit: in FAULT with ptch=0 and rider present -> stays FAULT. Rider removed for 4 nxt -> IDLE, tilt_flt=0.
6. Override: in RAMP, drop pwr_req coincident with the fault counter reaching FAULT_SMPLS -> OFF, not FAULT. Assert rst mid-BAL -> all outputs at reset values next edge.
